// File: rtl/adc_acq_pkg.sv
// Shared definitions for the ADC acquisition scheduler.
// Holds the FSM state type, default parameter values, the derived frame length
// (trigger to sample strobe) and a default trigger period.
package adc_acq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_CH_W       = 2;
    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_CLK_DIV    = 2;
    localparam int unsigned DEF_SETTLE_CYC = 4;

    localparam logic [15:0] DEF_PERIOD = 16'd200;

    // Cycles from trigger to sample strobe: settle + setup + shift + hold + done.
    function automatic int unsigned frame_cyc(input int unsigned settle_cyc,
                                              input int unsigned clk_div,
                                              input int unsigned data_w);
        return settle_cyc + 1 + 2 * clk_div * data_w + 1 + 1;
    endfunction

    localparam int unsigned FRAME_CYC = frame_cyc(DEF_SETTLE_CYC, DEF_CLK_DIV, DEF_DATA_W);

endpackage

// File: rtl/adc_rr_pick.sv
// Combinational round-robin picker.
// Finds the first set bit of ch_mask_i searching last_ch_i+1, last_ch_i+2, ...
// modulo NUM_CH.
//   ch_mask_i : per-channel enable mask
//   last_ch_i : channel served most recently
//   next_ch_o : channel to serve next (only meaningful when any_o is high)
//   any_o     : at least one channel enabled
module adc_rr_pick
    import adc_acq_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned CH_W   = DEF_CH_W
) (
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [CH_W-1:0]   last_ch_i,
    output logic [CH_W-1:0]   next_ch_o,
    output logic              any_o
);

    logic [CH_W-1:0] idx;

    // Walk the search order backwards so the nearest candidate is written last.
    always_comb begin
        next_ch_o = last_ch_i;
        any_o     = |ch_mask_i;
        idx       = '0;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = CH_W'((int'(last_ch_i) + i) % NUM_CH);
            if (ch_mask_i[idx]) begin
                next_ch_o = idx;
            end
        end
    end

endmodule

// File: rtl/adc_acq_sched.sv
// Multi-channel acquisition scheduler for the serial ADC path.
// A period timer triggers conversions; each trigger picks the next enabled channel
// round-robin, drives the analog mux, runs one serial frame and strobes the result.
//   clk_100, reset        : system clock, synchronous active-high reset
//   enable_i              : run; low aborts the frame and clears overrun
//   ch_mask_i             : channels to scan
//   period_cfg_i          : trigger period in clk_100 cycles, 0 disables
//   mdi_i                 : ADC serial data in
//   sck_o, cs_n_o         : ADC serial clock (idles low), chip select (idles high)
//   mux_sel_o             : analog mux select
//   sample_data_o/_ch_o   : last completed conversion and its channel
//   sample_valid_o        : one-cycle new-sample strobe
//   busy_o, overrun_o     : FSM not idle; sticky dropped-trigger flag
module adc_acq_sched
    import adc_acq_pkg::*;
#(
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned CH_W       = DEF_CH_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC
) (
    input  logic              clk_100,
    input  logic              reset,
    input  logic              enable_i,
    input  logic [NUM_CH-1:0] ch_mask_i,
    input  logic [15:0]       period_cfg_i,
    input  logic              mdi_i,
    output logic              sck_o,
    output logic              cs_n_o,
    output logic [CH_W-1:0]   mux_sel_o,
    output logic [DATA_W-1:0] sample_data_o,
    output logic [CH_W-1:0]   sample_ch_o,
    output logic              sample_valid_o,
    output logic              busy_o,
    output logic              overrun_o
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > CLK_DIV) ? SETTLE_CYC : CLK_DIV;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = $clog2(DATA_W + 1);

    state_e              state_q, state_d;
    logic [15:0]         per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                phase_q, phase_d;
    logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]   sample_data_q, sample_data_d;
    logic [CH_W-1:0]     sample_ch_q, sample_ch_d;
    logic                sample_valid_q, sample_valid_d;
    logic                overrun_q, overrun_d;
    logic [CH_W-1:0]     last_ch_q, last_ch_d;
    logic [CH_W-1:0]     mux_sel_q, mux_sel_d;

    logic                tick;
    logic [CH_W-1:0]     pick_ch;
    logic                pick_any;

    adc_rr_pick #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_rr_pick (
        .ch_mask_i (ch_mask_i),
        .last_ch_i (last_ch_q),
        .next_ch_o (pick_ch),
        .any_o     (pick_any)
    );

    // Period timer; period_cfg_i is compared live.
    always_comb begin
        tick      = enable_i && (period_cfg_i != '0) && (per_cnt_q == period_cfg_i - 16'd1);
        per_cnt_d = per_cnt_q + 16'd1;
        if (!enable_i || (period_cfg_i == '0) || tick) begin
            per_cnt_d = '0;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        phase_d        = phase_q;
        bit_cnt_d      = bit_cnt_q;
        shift_d        = shift_q;
        sample_data_d  = sample_data_q;
        sample_ch_d    = sample_ch_q;
        sample_valid_d = 1'b0;
        overrun_d      = overrun_q;
        last_ch_d      = last_ch_q;
        mux_sel_d      = mux_sel_q;

        if (!enable_i) begin
            // Abort: results and round-robin position are retained.
            state_d   = StIdle;
            overrun_d = 1'b0;
            cnt_d     = '0;
            phase_d   = 1'b0;
            bit_cnt_d = '0;
        end else begin
            // DONE counts as busy, so a tick there is also dropped.
            if (tick && (state_q != StIdle)) begin
                overrun_d = 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (tick && pick_any) begin
                        state_d   = StSettle;
                        last_ch_d = pick_ch;
                        mux_sel_d = pick_ch;
                        cnt_d     = '0;
                    end
                end
                StSettle: begin
                    if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
                        state_d = StSetup;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StSetup: begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    phase_d   = 1'b0;
                    bit_cnt_d = '0;
                end
                StShift: begin
                    if (cnt_q == CNT_W'(CLK_DIV - 1)) begin
                        cnt_d = '0;
                        if (!phase_q) begin
                            // sck rises next cycle: capture the bit presented while low.
                            phase_d = 1'b1;
                            shift_d = {shift_q[DATA_W-2:0], mdi_i};
                        end else begin
                            phase_d = 1'b0;
                            if (bit_cnt_q == BIT_W'(DATA_W - 1)) begin
                                state_d = StHold;
                            end else begin
                                bit_cnt_d = bit_cnt_q + BIT_W'(1);
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                StHold: begin
                    state_d        = StDone;
                    sample_data_d  = shift_q;
                    sample_ch_d    = last_ch_q;
                    sample_valid_d = 1'b1;
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_100) begin
        if (reset) begin
            state_q        <= StIdle;
            per_cnt_q      <= '0;
            cnt_q          <= '0;
            phase_q        <= 1'b0;
            bit_cnt_q      <= '0;
            shift_q        <= '0;
            sample_data_q  <= '0;
            sample_ch_q    <= '0;
            sample_valid_q <= 1'b0;
            overrun_q      <= 1'b0;
            last_ch_q      <= CH_W'(NUM_CH - 1);
            mux_sel_q      <= '0;
        end else begin
            state_q        <= state_d;
            per_cnt_q      <= per_cnt_d;
            cnt_q          <= cnt_d;
            phase_q        <= phase_d;
            bit_cnt_q      <= bit_cnt_d;
            shift_q        <= shift_d;
            sample_data_q  <= sample_data_d;
            sample_ch_q    <= sample_ch_d;
            sample_valid_q <= sample_valid_d;
            overrun_q      <= overrun_d;
            last_ch_q      <= last_ch_d;
            mux_sel_q      <= mux_sel_d;
        end
    end

    assign busy_o         = (state_q != StIdle);
    assign cs_n_o         = !((state_q == StSetup) || (state_q == StShift) || (state_q == StHold));
    assign sck_o          = (state_q == StShift) && phase_q;
    assign mux_sel_o      = mux_sel_q;
    assign sample_data_o  = sample_data_q;
    assign sample_ch_o    = sample_ch_q;
    assign sample_valid_o = sample_valid_q;
    assign overrun_o      = overrun_q;

endmodule

// File: doc/adc_acq_sched.md
Name: adc_acq_sched

Overview:
- Multi-channel acquisition scheduler for the serial 16-bit ADC path.
- A programmable period timer triggers conversions. Each trigger selects the next enabled analog channel round-robin and drives the analog mux select.
- Runs one serial conversion frame (cs_n, sck, mdi) and presents each result with its channel tag as a one-cycle valid strobe to downstream processing.
- Sits between the ADC (real device or its imitator) and the sample-processing logic on the clk_100 domain.

Parameters:
- NUM_CH, 4, number of analog mux channels.
- CH_W, 2, width of channel index; must satisfy 2**CH_W >= NUM_CH.
- DATA_W, 16, bits per conversion frame, MSB first.
- CLK_DIV, 2, sck half-period in clk_100 cycles; must be >= 1.
- SETTLE_CYC, 4, mux settling cycles before cs_n falls; must be >= 1.

Ports:
- clk_100 in 1 system clock, 100 MHz.
- reset in 1: synchronous, active-high reset; clock is clk_100.
- enable in 1: run scheduler. Low aborts any conversion and clears overrun.
- ch_mask in NUM_CH: per-channel enable; bit i set means channel i is scanned.
- period_cfg in 16: trigger period in clk_100 cycles; 0 disables triggering.
- mdi in 1: ADC serial data.
- sck out 1: ADC serial clock, idles low.
- cs_n out 1: ADC chip select, active low, idles high.
- mux_sel out CH_W: analog mux channel select.
- sample_data out DATA_W: last completed conversion.
- sample_ch out CH_W: channel of sample_data.
- sample_valid out 1: one-cycle strobe, new sample.
- busy out 1: high whenever FSM is not IDLE.
- overrun out 1: sticky flag, trigger dropped while busy.

Behaviour:
- Reset values:
  - sck=0, cs_n=1, mux_sel=0, sample_data=0, sample_ch=0, sample_valid=0, busy=0, overrun=0.
  - Period counter=0; round-robin pointer last_ch=NUM_CH-1, so channel 0 is served first.
- Period timer:
  - When enable=1 and period_cfg!=0, the counter counts 0..period_cfg-1 and wraps.
  - tick is asserted in the cycle the count equals period_cfg-1.
  - When enable=0 or period_cfg=0, the counter is held at 0 and no tick is produced.
  - period_cfg is used live; a change takes effect from the next compare.
- Channel pick:
  - On a tick in IDLE with ch_mask!=0, select the first set bit searching last_ch+1, last_ch+2, ... modulo NUM_CH.
  - last_ch is updated to that channel and mux_sel is registered at T+1.
  - ch_mask=0: the tick is ignored; no overrun, FSM stays IDLE.
- FSM states: IDLE -> SETTLE -> SETUP -> SHIFT -> HOLD -> DONE -> IDLE.
  - SETTLE: lasts SETTLE_CYC cycles; cs_n=1, sck=0.
  - SETUP: 1 cycle, cs_n=0, sck=0.
  - SHIFT: DATA_W bit periods, each CLK_DIV cycles sck=0 then CLK_DIV cycles sck=1. mdi is shifted into the LSB of the shift register on the cycle sck goes 0->1. First bit captured is the MSB.
  - HOLD: 1 cycle; sck=0, cs_n=0. cs_n returns to 1 on entry to DONE.
  - DONE: 1 cycle. sample_data is loaded from the shift register, sample_ch from last_ch, and sample_valid=1. Then IDLE.
- Frame length:
  - Tick to sample_valid = SETTLE_CYC + 1 + 2*CLK_DIV*DATA_W + 1 + 1 cycles.
  - With defaults this is 71 cycles.
- Overrun:
  - A tick arriving while FSM != IDLE sets overrun; the tick is dropped and the current frame continues unaffected.
  - overrun is cleared only by reset or enable=0.
  - A tick in the same cycle DONE->IDLE counts as busy, so overrun is set.
- enable falling mid-frame:
  - Next cycle: FSM=IDLE, cs_n=1, sck=0, no sample_valid.
  - sample_data and sample_ch keep their previous values; last_ch is retained.
- ch_mask changing mid-frame does not affect the current frame; the new mask is used at the next pick.
- reset mid-frame forces all reset values on the next edge and has priority over all other inputs.
- sample_data and sample_ch are stable between strobes.

Decomposition:
- Package adc_acq_pkg holds:
  - The FSM state enum (IDLE, SETTLE, SETUP, SHIFT, HOLD, DONE).
  - Localparam FRAME_CYC derived from the parameters.
  - A default period constant.
- One natural sub-module: adc_rr_pick.
  - Combinational round-robin first-set-bit search.
  - Inputs: ch_mask, last_ch. Outputs: next_ch, any.
  - Reusable by other schedulers.
- Period timer and serial engine stay inline.

Test Plan:
- Single channel, data captured: ch_mask=4'b0001, period_cfg=200, ADC model drives 16'hA5C3 -> sample_valid every 200 cycles, sample_ch=0, sample_data=16'hA5C3; tick to valid = 71 cycles; cs_n low for exactly 2+64 cycles; 16 sck rising edges.
- Round-robin skipping: ch_mask=4'b1011, period_cfg=100, model returns 16'h1000+channel -> sample_ch sequence 0,1,3,0,1,3 with matching data; mux_sel changes 1 cycle after each tick.
- Overrun: period_cfg=50 (< 71) -> overrun=1 at the second tick, every other tick is dropped, samples continue every 100 cycles; enable pulsed low 1 cycle -> overrun=0.
- Abort: enable=0 at bit 8 of SHIFT -> next cycle cs_n=1, sck=0, busy=0, no sample_valid; sample_data still equals the prior value.
- Empty mask and disabled timer: ch_mask=0 for 1000 cycles, then period_cfg=0 with mask 4'b1111 -> cs_n stays 1, busy=0, overrun=0, no strobes.
- Reset mid-frame: assert reset during SHIFT -> all outputs at reset values next cycle; after release, the first sample is on channel 0.
